// File: rtl/intpol2_pkg.sv
// Shared encodings for the interpolator output-side capture logic.
package intpol2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } cap_state_e;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RING    = 1'b1;

endpackage

// File: rtl/capture_addr_gen.sv
// Capture memory address and per-pass write count, with clear, increment and wrap at len-1.
module capture_addr_gen #(
    parameter int unsigned ADDR_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  inc_i,
    input  logic [ADDR_WIDTH-1:0] len_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [ADDR_WIDTH-1:0] count_o
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [ADDR_WIDTH-1:0] last_addr;

    assign last_addr = len_i - 1'b1;

    always_comb begin
        addr_d  = addr_q;
        count_d = count_q;
        if (clr_i) begin
            addr_d  = '0;
            count_d = '0;
        end else if (inc_i) begin
            addr_d  = (addr_q == last_addr) ? '0 : addr_q + 1'b1;
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

    assign addr_o  = addr_q;
    assign count_o = count_q;

endmodule

// File: rtl/stream_capture_ctrl.sv
// Drains NCH lock-stepped show-ahead FIFOs into capture memory, one-shot or as a ring.
module stream_capture_ctrl
    import intpol2_pkg::*;
#(
    parameter int unsigned NCH        = 2,
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned ADDR_WIDTH = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic                      nop_i,
    input  logic                      mode_i,
    input  logic [ADDR_WIDTH-1:0]     len_i,
    input  logic [NCH-1:0]            empty_i,
    input  logic [NCH*DATA_WIDTH-1:0] data_i,
    output logic                      Read_Enable_o,
    output logic                      Write_Enable_o,
    output logic [ADDR_WIDTH-1:0]     addr_o,
    output logic [NCH*DATA_WIDTH-1:0] data_o,
    output logic [ADDR_WIDTH-1:0]     count_o,
    output logic                      busy_o,
    output logic                      done_o
);

    cap_state_e                state_q;
    logic [ADDR_WIDTH-1:0]     len_q;
    logic                      mode_q;
    logic [ADDR_WIDTH-1:0]     rd_cnt_q;
    logic [ADDR_WIDTH-1:0]     rd_cnt_nxt;
    logic                      we_q;
    logic [NCH*DATA_WIDTH-1:0] data_q;
    logic                      re;
    logic                      clr;

    assign rd_cnt_nxt = rd_cnt_q + 1'b1;

    // Reads stop the same cycle an abort or reset arrives so no sample is popped and dropped.
    assign re = ~rst & ~abort_i & (state_q == ST_RUN) & ~(|empty_i) & ~nop_i
              & (rd_cnt_q < len_q);

    assign clr = ~abort_i & ((state_q == ST_ARM) |
                             ((state_q == ST_DONE) & (mode_q == MODE_RING)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            mode_q   <= MODE_ONESHOT;
            rd_cnt_q <= '0;
            we_q     <= 1'b0;
            data_q   <= '0;
        end else begin
            we_q <= re;
            if (re) begin
                data_q   <= data_i;
                rd_cnt_q <= rd_cnt_nxt;
            end
            if (abort_i) begin
                state_q <= ST_IDLE;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (start_i) begin
                            state_q <= ST_ARM;
                            len_q   <= len_i;
                            mode_q  <= mode_i;
                        end
                    end
                    ST_ARM: begin
                        rd_cnt_q <= '0;
                        state_q  <= (len_q == '0) ? ST_DONE : ST_RUN;
                    end
                    ST_RUN: begin
                        if (re && (rd_cnt_nxt == len_q)) state_q <= ST_DRAIN;
                    end
                    ST_DRAIN: state_q <= ST_DONE;
                    ST_DONE: begin
                        if (mode_q == MODE_RING) begin
                            rd_cnt_q <= '0;
                            state_q  <= ST_RUN;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    capture_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .inc_i  (we_q),
        .len_i  (len_q),
        .addr_o (addr_o),
        .count_o(count_o)
    );

    assign Read_Enable_o  = re;
    assign Write_Enable_o = we_q;
    assign data_o         = data_q;
    assign done_o         = (state_q == ST_DONE);
    // A ring capture is still busy while it pulses done between passes.
    assign busy_o = (state_q == ST_ARM) | (state_q == ST_RUN) | (state_q == ST_DRAIN) |
                    ((state_q == ST_DONE) & (mode_q == MODE_RING));

endmodule

// File: tb/tb_stream_capture_ctrl.sv
// Directed bench for stream_capture_ctrl with show-ahead FIFO models and a write log.
module tb_stream_capture_ctrl;

    localparam int unsigned NCH = 2;
    localparam int unsigned DW  = 12;
    localparam int unsigned AW  = 20;

    logic              clk = 1'b0;
    logic              rst, start_i, abort_i, nop_i, mode_i;
    logic [AW-1:0]     len_i;
    logic [NCH-1:0]    empty_i;
    logic [NCH*DW-1:0] data_i;
    logic              Read_Enable_o, Write_Enable_o, busy_o, done_o;
    logic [AW-1:0]     addr_o, count_o;
    logic [NCH*DW-1:0] data_o;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc_n = 0, n_re = 0, n_bad_re = 0, n_done = 0, done_busy = 0;
    int last_we_cyc = 0, done_cyc = 0, busy_at_last_we = 0;
    logic [AW-1:0]     count_at_done;
    logic              force_e1 = 1'b0;
    logic [DW-1:0]     fq0[$];
    logic [DW-1:0]     fq1[$];
    logic [AW-1:0]     wr_addr[$];
    logic [NCH*DW-1:0] wr_data[$];

    always #5 clk = ~clk;

    stream_capture_ctrl #(
        .NCH       (NCH),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .nop_i         (nop_i),
        .mode_i        (mode_i),
        .len_i         (len_i),
        .empty_i       (empty_i),
        .data_i        (data_i),
        .Read_Enable_o (Read_Enable_o),
        .Write_Enable_o(Write_Enable_o),
        .addr_o        (addr_o),
        .data_o        (data_o),
        .count_o       (count_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        empty_i[0]    = (fq0.size() == 0);
        empty_i[1]    = (fq1.size() == 0) || force_e1;
        data_i[DW-1:0]    = (fq0.size() != 0) ? fq0[0] : '0;
        data_i[2*DW-1:DW] = (fq1.size() != 0) ? fq1[0] : '0;
    endtask

    task automatic push_samples(input int n, input int b0, input int b1);
        logic [DW-1:0] v0, v1;
        for (int i = 0; i < n; i++) begin
            v0 = DW'(b0 + i);
            v1 = DW'(b1 + i);
            fq0.push_back(v0);
            fq1.push_back(v1);
        end
        drive_fifo();
    endtask

    task automatic flush();
        fq0.delete();
        fq1.delete();
        drive_fifo();
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        n_re = 0; n_bad_re = 0; n_done = 0; done_busy = 0;
    endtask

    // Sample at the falling edge, then pop the FIFO models just after the rising edge.
    task automatic cyc();
        logic re_s;
        @(negedge clk);
        re_s = (Read_Enable_o === 1'b1);
        if (re_s) begin
            n_re++;
            if (nop_i || (|empty_i)) n_bad_re++;
        end
        if (Write_Enable_o === 1'b1) begin
            wr_addr.push_back(addr_o);
            wr_data.push_back(data_o);
            last_we_cyc     = cyc_n;
            busy_at_last_we = int'(busy_o);
        end
        if (done_o === 1'b1) begin
            n_done++;
            done_cyc      = cyc_n;
            count_at_done = count_o;
            if (busy_o === 1'b1) done_busy++;
        end
        cyc_n++;
        @(posedge clk);
        #1;
        if (re_s) begin
            if (fq0.size() != 0) void'(fq0.pop_front());
            if (fq1.size() != 0) void'(fq1.pop_front());
        end
        drive_fifo();
    endtask

    task automatic pulse_start(input int len, input logic mode);
        start_i = 1'b1;
        len_i   = AW'(len);
        mode_i  = mode;
        cyc();
        start_i = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        for (int i = 0; i < budget && n_done == 0; i++) cyc();
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, " RE"},    Read_Enable_o,  0);
        check({pfx, " WE"},    Write_Enable_o, 0);
        check({pfx, " addr"},  addr_o,         0);
        check({pfx, " data"},  data_o,         0);
        check({pfx, " count"}, count_o,        0);
        check({pfx, " busy"},  busy_o,         0);
        check({pfx, " done"},  done_o,         0);
    endtask

    task automatic check_writes(input string pfx, input int n, input int b0, input int b1,
                                input int ring);
        logic [DW-1:0]     e0, e1;
        logic [NCH*DW-1:0] ed;
        check({pfx, " nwrites"}, wr_addr.size(), n);
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            e0 = DW'(b0 + i);
            e1 = DW'(b1 + i);
            ed = {e1, e0};
            check($sformatf("%s addr[%0d]", pfx, i), wr_addr[i], i % ring);
            check($sformatf("%s data[%0d]", pfx, i), wr_data[i], ed);
        end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; nop_i = 1'b0; mode_i = 1'b0;
        len_i = '0;
        drive_fifo();
        repeat (3) cyc();
        check_outputs_zero("reset");
        rst = 1'b0;
        cyc();

        // One-shot, len 10.
        push_samples(10, 'h001, 'h801);
        clear_log();
        pulse_start(10, 1'b0);
        run_until_done(40);
        check("t1 ndone", n_done, 1);
        check("t1 count at done", count_at_done, 10);
        check("t1 done after last write", done_cyc - last_we_cyc, 1);
        check("t1 busy with done", done_busy, 0);
        check("t1 busy on last write", busy_at_last_we, 1);
        check("t1 busy after", busy_o, 0);
        check_writes("t1", 10, 'h001, 'h801, 10);

        // len 0: done without reads.
        push_samples(3, 'h100, 'h900);
        clear_log();
        pulse_start(0, 1'b0);
        for (int i = 0; i < 2 && n_done == 0; i++) cyc();
        check("t2 ndone", n_done, 1);
        check("t2 reads", n_re, 0);
        check("t2 count at done", count_at_done, 0);
        check("t2 nwrites", wr_addr.size(), 0);
        check("t2 busy after", busy_o, 0);
        flush();

        // Ring, len 8, 20 samples, then abort.
        push_samples(20, 'h021, 'hA21);
        clear_log();
        pulse_start(8, 1'b1);
        for (int i = 0; i < 100 && wr_addr.size() < 20; i++) cyc();
        repeat (3) cyc();
        check("t3 ndone", n_done, 2);
        check("t3 busy with done", done_busy, 2);
        check("t3 busy running", busy_o, 1);
        check("t3 count", count_o, 4);
        check_writes("t3", 20, 'h021, 'hA21, 8);
        abort_i = 1'b1;
        cyc();
        abort_i = 1'b0;
        check("t3 busy after abort", busy_o, 0);
        repeat (4) cyc();
        check("t3 ndone after abort", n_done, 2);
        check("t3 count holds", count_o, 4);

        // nop and channel-1 empty stalls.
        push_samples(16, 'h300, 'hB00);
        clear_log();
        pulse_start(16, 1'b0);
        for (int k = 0; k < 400 && n_done == 0; k++) begin
            nop_i    = ((k % 7) < 5);
            force_e1 = ($urandom_range(0, 2) == 0);
            drive_fifo();
            cyc();
        end
        nop_i = 1'b0; force_e1 = 1'b0;
        drive_fifo();
        check("t4 ndone", n_done, 1);
        check("t4 RE while stalled", n_bad_re, 0);
        check("t4 reads", n_re, 16);
        check_writes("t4", 16, 'h300, 'hB00, 16);

        // Reset mid-run, then a clean len 4 capture.
        push_samples(10, 'h400, 'hC00);
        clear_log();
        pulse_start(10, 1'b0);
        for (int i = 0; i < 50 && wr_addr.size() < 5; i++) cyc();
        check("t5 writes before rst", wr_addr.size(), 5);
        rst = 1'b1;
        cyc();
        check_outputs_zero("t5 rst");
        rst = 1'b0;
        flush();
        clear_log();
        push_samples(4, 'h500, 'hD00);
        pulse_start(4, 1'b0);
        run_until_done(30);
        check("t5 ndone", n_done, 1);
        check("t5 count at done", count_at_done, 4);
        check_writes("t5", 4, 'h500, 'hD00, 4);

        // start+abort together stays idle; a start during RUN is ignored.
        push_samples(4, 'h600, 'hE00);
        clear_log();
        start_i = 1'b1; abort_i = 1'b1; len_i = AW'(4); mode_i = 1'b0;
        cyc();
        start_i = 1'b0; abort_i = 1'b0;
        repeat (2) cyc();
        check("t6 busy after start+abort", busy_o, 0);
        check("t6 reads after start+abort", n_re, 0);
        check("t6 ndone after start+abort", n_done, 0);
        pulse_start(4, 1'b0);
        for (int i = 0; i < 20 && wr_addr.size() < 2; i++) cyc();
        pulse_start(2, 1'b1);
        run_until_done(30);
        check("t6 ndone", n_done, 1);
        check("t6 count at done", count_at_done, 4);
        check("t6 busy after", busy_o, 0);
        check_writes("t6", 4, 'h600, 'hE00, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
